// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, widths, default divider.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_DIV_W     = 16;

  // 115200 baud from a 50 MHz clock: 50e6 / 115200 - 1
  localparam logic [UART_DIV_W-1:0] UART_DIV_115200 = 16'd433;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_rx_state_e;

  // 2-of-3 vote used by the majority-sampling build
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with valid/ready on both sides, synchronous flush and occupancy count.
module fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rstz,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_vld,
  output logic                   din_rdy,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_vld,
  input  logic                   dout_rdy,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FullCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CntOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push, pop;

  assign din_rdy  = (cnt_q != FullCnt);
  assign dout_vld = (cnt_q != '0);
  assign push     = din_vld & din_rdy;
  assign pop      = dout_vld & dout_rdy;
  assign dout     = mem_q[rptr_q];
  assign cnt      = cnt_q;

  // Pointers and occupancy; flush wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      if (push != pop) cnt_q <= push ? cnt_q + CntOne : cnt_q - CntOne;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with receive FIFO and single-beat read port.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BUFFER = 32
) (
  input  logic                  clk,
  input  logic                  rstz,
  input  logic                  rx,
  input  logic [UART_DIV_W-1:0] divider,
  input  logic                  clear,
  output logic                  full,
  output logic                  empty,
  output logic [15:0]           size,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [7:0]            dat_o,
  input  logic                  we_i,
  input  logic                  stb_i,
  output logic                  ack_o
);
  localparam int unsigned CntW = $clog2(BUFFER) + 1;
  localparam logic [2:0]  LastBit = 3'(UART_DATA_BITS - 1);

  logic sync1_q, rxs_q, rxs_prev_q;
  logic fall, sample, tick;

  uart_rx_state_e           state_q, state_d;
  logic [UART_DIV_W-1:0]    timer_q, timer_d, mid_start;
  logic [2:0]               bitcnt_q, bitcnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                     frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                     push;

  logic                     fifo_rdy, fifo_vld, rd, pop;
  logic [7:0]               fifo_dout;
  logic [CntW-1:0]          fifo_cnt;
  logic                     full_q, empty_q, ack_q;
  logic [7:0]               dat_q;

  // Two-flop synchronizer plus a third flop for falling-edge detection
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall      = rxs_prev_q & ~rxs_q;
  assign tick      = (timer_q == divider);
  assign mid_start = divider >> 1;

`ifdef UART_RX_MAJORITY_EN
  // sync1_q is next cycle's rxs and rxs_prev_q the previous one, so the vote spans mid-1..mid+1
  // with no extra latency; bits shorter than 3 clocks fall back to the single centre sample.
  assign sample = (divider >= 16'd2) ? maj3(rxs_prev_q, rxs_q, sync1_q) : rxs_q;
`else
  assign sample = rxs_q;
`endif

  // Frame FSM state register
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame FSM next state; the edge-detect cycle counts as timer 0 of the start bit
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 16'd1;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    push        = 1'b0;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (fall) begin
          if (mid_start == '0) begin
            // Start sample lands on the edge-detect cycle itself
            if (!sample) begin
              state_d  = StData;
              bitcnt_d = '0;
            end
          end else begin
            state_d = StStart;
            timer_d = 16'd1;
          end
        end
      end
      StStart: begin
        if (timer_q == mid_start) begin
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = sample ? StIdle : StData;
        end
      end
      StData: begin
        if (tick) begin
          timer_d  = '0;
          shift_d  = {sample, shift_q[UART_DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == LastBit) state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          timer_d = '0;
          state_d = StIdle;
          if (sample) begin
            push = 1'b1;
            if (!fifo_rdy) overrun_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  assign rd  = stb_i & ~we_i;
  assign pop = rd & fifo_vld & ~clear;

  fifo #(
    .WIDTH(8),
    .DEPTH(BUFFER)
  ) u_fifo (
    .clk      (clk),
    .rstz     (rstz),
    .clear    (clear),
    .din      (shift_q),
    .din_vld  (push),
    .din_rdy  (fifo_rdy),
    .dout     (fifo_dout),
    .dout_vld (fifo_vld),
    .dout_rdy (rd),
    .cnt      (fifo_cnt)
  );

  // Registered status, acknowledge and read data
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ack_q   <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      full_q  <= ~fifo_rdy;
      empty_q <= ~fifo_vld;
      ack_q   <= stb_i;
      if (rd) dat_q <= pop ? fifo_dout : 8'h00;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign size      = 16'(fifo_cnt);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign ack_o     = ack_q;
  assign dat_o     = dat_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of single frames, hand-written corner sequences and
// a randomized run against a queue-based reference model.
module tb_uart_rx;
  localparam int unsigned BUF = 4;

  logic        clk = 1'b0;
  logic        rstz, rx, clear, we_i, stb_i;
  logic [15:0] divider;
  logic        full, empty, frame_err, overrun, ack_o;
  logic [15:0] size;
  logic [7:0]  dat_o;

  always #5 clk = ~clk;

  uart_rx #(
    .BUFFER(BUF)
  ) dut (
    .clk       (clk),
    .rstz      (rstz),
    .rx        (rx),
    .divider   (divider),
    .clear     (clear),
    .full      (full),
    .empty     (empty),
    .size      (size),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dat_o     (dat_o),
    .we_i      (we_i),
    .stb_i     (stb_i),
    .ack_o     (ack_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: received bytes in order, plus the two sticky flags
  logic [7:0] mq[$];
  logic       m_fe, m_ov;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic        stop;
    logic [7:0]  exp_dat;
    logic        exp_fe;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame, each line clock index k held from just after edge k to edge k+1.
  // cut stops driving early (line returns high); spike inverts the line for index spike only.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [15:0] d,
                            input int cut, input int spike);
    logic [9:0] bits;
    int         per;
    bits    = {stop, b, 1'b0};
    per     = int'(d) + 1;
    divider = d;
    for (int k = 0; k < 10 * per; k++) begin
      if (k < cut) begin
        @(posedge clk);
        #1;
        rx = bits[k / per] ^ (k == spike);
      end
    end
    @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  // Good frames land in the model unless it is full; bad stop bits only raise the flag
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_fe = 1'b1;
    else if (mq.size() < BUF) mq.push_back(b);
    else m_ov = 1'b1;
  endtask

  task automatic do_read(input string name, input logic [7:0] exp);
    @(posedge clk);
    #1;
    stb_i = 1'b1;
    we_i  = 1'b0;
    @(posedge clk);
    #1;
    stb_i = 1'b0;
    @(negedge clk);
    check({name, "_ack"}, 16'(ack_o), 16'd1);
    check({name, "_dat"}, 16'(dat_o), 16'(exp));
    wait_clk(1);
  endtask

  task automatic model_read(input string name);
    logic [7:0] e;
    e = (mq.size() > 0) ? mq.pop_front() : 8'h00;
    do_read(name, e);
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    wait_clk(1);
    mq.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic check_status(input string name);
    @(negedge clk);
    check({name, "_size"}, size, 16'(mq.size()));
    check({name, "_empty"}, 16'(empty), 16'(mq.size() == 0));
    check({name, "_full"}, 16'(full), 16'(mq.size() == BUF));
    check({name, "_ferr"}, 16'(frame_err), 16'(m_fe));
    check({name, "_ovr"}, 16'(overrun), 16'(m_ov));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       st;
    logic [15:0] d;
    logic [7:0] exp_spike;

    vecs[0] = '{16'd3, 8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{16'd0, 8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[2] = '{16'd1, 8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{16'd2, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{16'd7, 8'h3C, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{16'd5, 8'h81, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{16'd9, 8'hC3, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{16'd4, 8'h7E, 1'b1, 8'h7E, 1'b0};

    rstz = 1'b0; rx = 1'b1; clear = 1'b0; we_i = 1'b0; stb_i = 1'b0; divider = 16'd3;
    mq.delete(); m_fe = 1'b0; m_ov = 1'b0;
    wait_clk(3);
    @(negedge clk);
    check("rst_full", 16'(full), 16'd0);
    check("rst_empty", 16'(empty), 16'd1);
    check("rst_size", size, 16'd0);
    check("rst_ferr", 16'(frame_err), 16'd0);
    check("rst_ovr", 16'(overrun), 16'd0);
    check("rst_ack", 16'(ack_o), 16'd0);
    check("rst_dat", 16'(dat_o), 16'd0);
    rstz = 1'b1;
    wait_clk(3);

    // Table of single frames across dividers, including divider 0 and bad stop bits
    foreach (vecs[i]) begin
      do_clear();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].div, 1 << 30, -1);
      wait_clk(6);
      @(negedge clk);
      check($sformatf("vec%0d_ferr", i), 16'(frame_err), 16'(vecs[i].exp_fe));
      check($sformatf("vec%0d_empty", i), 16'(empty), 16'(vecs[i].exp_fe));
      do_read($sformatf("vec%0d_rd", i), vecs[i].exp_dat);
      wait_clk(1);
      @(negedge clk);
      check($sformatf("vec%0d_empty_after", i), 16'(empty), 16'd1);
      do_clear();
      @(negedge clk);
      check($sformatf("vec%0d_ferr_clr", i), 16'(frame_err), 16'd0);
    end

    // Write strobe: acked, nothing popped, ack drops the cycle after
    do_clear();
    send_frame(8'h42, 1'b1, 16'd3, 1 << 30, -1);
    wait_clk(6);
    @(posedge clk); #1; stb_i = 1'b1; we_i = 1'b1;
    @(posedge clk); #1; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    check("wr_ack", 16'(ack_o), 16'd1);
    check("wr_size", size, 16'd1);
    @(negedge clk);
    check("wr_ack_drop", 16'(ack_o), 16'd0);
    do_read("wr_then_rd", 8'h42);

    // One-clock low glitch is rejected and the receiver still takes the next frame
    do_clear();
    send_frame(8'h00, 1'b1, 16'd7, 1, -1);
    wait_clk(20);
    check_status("glitch");
    send_frame(8'h96, 1'b1, 16'd7, 1 << 30, -1);
    wait_clk(6);
    do_read("glitch_next", 8'h96);

    // Five bytes into a four-deep FIFO
    do_clear();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 16'd2, 1 << 30, -1);
      wait_clk(2);
    end
    wait_clk(4);
    @(negedge clk);
    check("ovr_full", 16'(full), 16'd1);
    check("ovr_flag", 16'(overrun), 16'd1);
    check("ovr_size", size, 16'd4);
    for (int i = 1; i <= 4; i++) do_read($sformatf("ovr_rd%0d", i), 8'(i));
    do_read("ovr_rd_empty", 8'h00);

    // Reset in the middle of a frame's data bits
    do_clear();
    send_frame(8'h55, 1'b1, 16'd3, 30, -1);
    @(posedge clk); #1; rstz = 1'b0;
    wait_clk(2);
    rstz = 1'b1;
    wait_clk(2);
    @(negedge clk);
    check("rstmid_empty", 16'(empty), 16'd1);
    send_frame(8'h81, 1'b1, 16'd3, 1 << 30, -1);
    wait_clk(6);
    @(negedge clk);
    check("rstmid_size", size, 16'd1);
    do_read("rstmid_rd", 8'h81);
    do_read("rstmid_rd_empty", 8'h00);

    // Spike at the centre of data bit 3 (line index 7 + 4*16) of 0x00 at divider 15
`ifdef UART_RX_MAJORITY_EN
    exp_spike = 8'h00;
`else
    exp_spike = 8'h08;
`endif
    do_clear();
    send_frame(8'h00, 1'b1, 16'd15, 1 << 30, 71);
    wait_clk(6);
    do_read("spike", exp_spike);

    // Randomized frames with random reads, checked against the model
    do_clear();
    for (int n = 0; n < 30; n++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      d  = 16'($urandom_range(0, 6));
      send_frame(b, st, d, 1 << 30, -1);
      model_frame(b, st);
      wait_clk(6);
      check_status($sformatf("rnd%0d", n));
      for (int r = 0; r < int'($urandom_range(0, 2)); r++) model_read($sformatf("rnd%0d_rd", n));
    end
    while (mq.size() > 0) model_read("rnd_drain");
    wait_clk(1);
    check_status("rnd_end");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
